// File: rtl/popcount_ctrl.sv
// Job sequencer/arbiter feeding the popcount core: merges DMA stream and MMIO words, latches RESULT.
// Zero-latency pass-through to PC_*; stream stalled via TREADY, MMIO never stalled (overflow -> STATUS_ERR[0]).
module popcount_ctrl #(
  parameter int MAX_STALL = 4,
  parameter int PIPE_LAT  = 1
) (
  input  logic        S_AXIS_ACLK,
  input  logic        S_AXIS_ARESET,
  input  logic        CTRL_START,
  input  logic        CTRL_ABORT,
  input  logic [31:0] CTRL_LEN_WORDS,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic [3:0]  S_AXIS_TKEEP,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] WRITE_DATA,
  input  logic        WRITE_VALID,
  output logic [31:0] PC_DATA,
  output logic        PC_VALID,
  output logic        PC_COUNT_RST,
  input  logic [31:0] PC_COUNT,
  output logic [31:0] RESULT,
  output logic [31:0] WORDS_DONE,
  output logic        STATUS_BUSY,
  output logic        STATUS_DONE,
  output logic [1:0]  STATUS_ERR,
  output logic        IRQ
);

  localparam int SW = $clog2(MAX_STALL + 1);
  localparam int GW = $clog2(PIPE_LAT + 1) + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [31:0]     words_q, words_d;
  logic [31:0]     result_q, result_d;
  logic [1:0]      err_q, err_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            irq_q, irq_d;

  logic [31:0]     keep_mask;
  logic [31:0]     words_inc;
  logic            mmio_issue, beat, issue, tready, abort;

  assign keep_mask = {{8{S_AXIS_TKEEP[3]}}, {8{S_AXIS_TKEEP[2]}},
                      {8{S_AXIS_TKEEP[1]}}, {8{S_AXIS_TKEEP[0]}}};
  assign words_inc = words_q + 32'd1;
  assign abort     = CTRL_ABORT && (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    stall_d      = stall_q;
    words_d      = words_q;
    result_d     = result_q;
    err_d        = err_q;
    gap_d        = (gap_q == {GW{1'b1}}) ? gap_q : gap_q + GW'(1);
    mmio_issue   = 1'b0;
    beat         = 1'b0;
    issue        = 1'b0;
    tready       = 1'b0;
    PC_DATA      = 32'd0;
    PC_COUNT_RST = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CTRL_START) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        PC_COUNT_RST = 1'b1;
        words_d      = 32'd0;
        err_d        = 2'b00;
        hold_vld_d   = 1'b0;
        stall_d      = '0;
        gap_d        = '0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        // A waiting MMIO word wins on an idle stream or once the stall budget is used up.
        mmio_issue = hold_vld_q && (!S_AXIS_TVALID || (stall_q == SW'(MAX_STALL)));
        if (mmio_issue) begin
          PC_DATA    = hold_q;
          hold_vld_d = 1'b0;
          stall_d    = '0;
        end else begin
          tready = 1'b1;
          beat   = S_AXIS_TVALID;
          if (beat) begin
            PC_DATA = S_AXIS_TDATA & keep_mask;
            if (hold_vld_q) stall_d = stall_q + SW'(1);
          end
        end
        issue = mmio_issue || beat;
        if (WRITE_VALID) begin
          if (!hold_vld_q || mmio_issue) begin
            hold_d     = WRITE_DATA;
            hold_vld_d = 1'b1;
          end else begin
            err_d[0] = 1'b1;
          end
        end
        if (issue) begin
          words_d = words_inc;
          gap_d   = GW'(1);
        end
        if (beat && S_AXIS_TLAST) begin
          state_d = ST_DRAIN;
          if ((CTRL_LEN_WORDS != 32'd0) && (words_inc < CTRL_LEN_WORDS)) err_d[1] = 1'b1;
        end
        if (issue && (CTRL_LEN_WORDS != 32'd0) && (words_inc == CTRL_LEN_WORDS))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (hold_vld_q) begin
          issue      = 1'b1;
          PC_DATA    = hold_q;
          hold_vld_d = 1'b0;
          words_d    = words_inc;
          gap_d      = GW'(1);
        end else if (gap_q >= GW'(PIPE_LAT)) begin
          result_d = PC_COUNT;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (CTRL_START) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the in-flight cycle entirely: nothing issued, accepted or counted.
    if (abort) begin
      state_d    = ST_IDLE;
      hold_vld_d = 1'b0;
      stall_d    = '0;
      words_d    = words_q;
      err_d      = err_q;
      result_d   = result_q;
      tready     = 1'b0;
      issue      = 1'b0;
      PC_DATA    = 32'd0;
    end

    irq_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q    <= ST_IDLE;
      hold_q     <= 32'd0;
      hold_vld_q <= 1'b0;
      stall_q    <= '0;
      words_q    <= 32'd0;
      result_q   <= 32'd0;
      err_q      <= 2'b00;
      gap_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      stall_q    <= stall_d;
      words_q    <= words_d;
      result_q   <= result_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
      irq_q      <= irq_d;
    end
  end

  assign S_AXIS_TREADY = tready;
  assign PC_VALID      = issue;
  assign RESULT        = result_q;
  assign WORDS_DONE    = words_q;
  assign STATUS_BUSY   = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign STATUS_DONE   = (state_q == ST_DONE);
  assign STATUS_ERR    = err_q;
  assign IRQ           = irq_q;

endmodule
